serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit unsigned subtractor: computes Diff = A - B, LSB first, one bit per clock.
//   Uses a single borrow flip-flop.
//   Inverse-operation companion to the half adder.
//   Its bit cell is the half subtractor (Diff = A ^ B, Borrow = ~A & B).
//   Serves as the area-minimal arithmetic unit in sequential lab datapaths.
// PARAMETERS
//   N      8    operand/result width in bits; N >= 2
// PORTS
//   clk     in   1   single clock; all state updates on rising edge
//   rst     in   1   synchronous, active-high reset
//   start   in   1   request; sampled only in IDLE
//   A       in   N   minuend; captured on accepted start
//   B       in   N   subtrahend; captured on accepted start
//   busy    out  1   high in RUN and DONE
//   done    out  1   one-cycle pulse; Diff/Borrow valid that cycle
//   Diff    out  N   (A - B) mod 2^N; held until next accepted start
//   Borrow  out  1   final borrow; 1 iff A < B (unsigned); held with Diff
// BEHAVIOUR
//   Reset (rst=1 at edge):
//     - state=IDLE; busy=0, done=0, Diff=0, Borrow=0.
//     - Internal shift regs, borrow FF and counter cleared.
//     - Reset dominates start.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE, start=1:
//     - Load A into shA and B into shB; bflag=0, cnt=0.
//     - Next state RUN.
//     - Diff/Borrow keep the previous result until RUN begins overwriting.
//   RUN, each cycle, full-subtract bit i from two half_subtractor cells:
//     - d  = shA[0] ^ shB[0] ^ bflag
//     - bo = (~shA[0] & shB[0]) | (~(shA[0] ^ shB[0]) & bflag)
//     - Diff <= {d, Diff[N-1:1]} (shift in at MSB).
//     - shA, shB shift right; bflag <= bo; cnt <= cnt+1.
//     - When cnt == N-1: Borrow <= bo; next state DONE.
//   DONE: done=1 for exactly one cycle; next state IDLE.
//   Latency: start accepted at edge t -> N RUN cycles -> done=1 in cycle t+N+1.
//     - Throughput: one operation per N+2 cycles.
//   start while busy (RUN or DONE): ignored, no queueing; A/B changes ignored.
//   start held high continuously: re-accepted on first IDLE cycle after DONE.
//   Diff is undefined-but-deterministic (partially shifted) during RUN.
//     - Consumers sample only on done.
//   rst mid-RUN: operation abandoned; all outputs zero next cycle; no done pulse.
//   cnt width: $clog2(N); no wrap, since the compare at N-1 ends RUN.
//   Edge results:
//     - A=B gives Diff=0, Borrow=0.
//     - 0-1 gives all-ones, Borrow=1.
// STRUCTURE
//   Include file serial_sub_defs.vh holds:
//     - FSM state localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//     - Default width constant.
//   Sub-module half_subtractor (ports A, B, Diff, Borrow; dataflow):
//     - Instantiated twice to form the full-subtract bit cell.
//     - Borrows OR-ed.
//   Top level holds FSM, shift registers, counter, borrow FF, output registers only.
// TESTING (N=8 unless noted)
//   1. A=8'h5A, B=8'h23, start pulse -> done exactly 9 cycles later; Diff=8'h37, Borrow=0.
//   2. A=8'h10, B=8'h20 -> Diff=8'hF0, Borrow=1.
//      Then A=8'hFF, B=8'hFF -> Diff=8'h00, Borrow=0.
//   3. A=8'h00, B=8'h01 -> Diff=8'hFF, Borrow=1.
//      Outputs stay held for 5 idle cycles after done.
//   4. Second start pulse and changed A/B during RUN -> ignored.
//      - Result still from first operands.
//      - Exactly one done pulse.
//   5. rst=1 at 4th RUN cycle -> next cycle busy=0, done=0, Diff=0, Borrow=0.
//      - New op A=8'h03, B=8'h01 then yields Diff=8'h02.
//   6. start tied high:
//      - back-to-back ops every 10 cycles;
//      - N=2 build: A=2'b01, B=2'b10 -> Diff=2'b11, Borrow=1.
//   Self-check every done against a reference model: {Borrow, Diff} == {1'b0,A} - {1'b0,B}.
//   Random sweep of 1000 operand pairs on top of the directed scenarios.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

   // Default operand/result width in bits.
   localparam int DEFAULT_WIDTH = 8;

   // Control states. The numeric values are fixed so that a state register
   // dump reads the same as the original lab documentation.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. The requester (master)
// drives start and the operands; the subtractor (slave) returns status and
// the held result.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int N = DEFAULT_WIDTH
) ();

   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] Diff;
   logic         Borrow;

   modport master (
      output start, A, B,
      input  busy, done, Diff, Borrow
   );

   modport slave (
      input  start, A, B,
      output busy, done, Diff, Borrow
   );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor: Diff = A - B with the borrow out.
// Two of these plus an OR gate make the full-subtract bit cell.
module half_subtractor (
   input  logic A,
   input  logic B,
   output logic Diff,
   output logic Borrow
);

   assign Diff   = A ^ B;
   assign Borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B, LSB first, one bit per clock,
// carrying a single borrow flip-flop between bit positions. A request takes
// N RUN cycles followed by a one-cycle DONE pulse.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N = DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   state_e           state_q, state_d;
   logic [N-1:0]     sha_q, sha_d;
   logic [N-1:0]     shb_q, shb_d;
   logic             bflag_q, bflag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     diff_q, diff_d;
   logic             borrow_q, borrow_d;

   // Full-subtract bit cell: first stage subtracts the operand bits, second
   // stage subtracts the incoming borrow; either stage may generate a borrow.
   logic hs0_diff, hs0_borrow;
   logic bit_diff, hs1_borrow;
   logic bit_borrow;

   half_subtractor u_hs_operands (
      .A      (sha_q[0]),
      .B      (shb_q[0]),
      .Diff   (hs0_diff),
      .Borrow (hs0_borrow)
   );

   half_subtractor u_hs_borrow (
      .A      (hs0_diff),
      .B      (bflag_q),
      .Diff   (bit_diff),
      .Borrow (hs1_borrow)
   );

   assign bit_borrow = hs0_borrow | hs1_borrow;

   // State, datapath and result registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sha_q    <= '0;
         shb_q    <= '0;
         bflag_q  <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sha_q    <= sha_d;
         shb_q    <= shb_d;
         bflag_q  <= bflag_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   // Next-state and datapath update: load on accepted start, shift one bit
   // per RUN cycle, latch the final borrow on the last bit.
   always_comb begin
      state_d  = state_q;
      sha_d    = sha_q;
      shb_d    = shb_q;
      bflag_d  = bflag_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;

      case (state_q)
         ST_IDLE: begin
            // The previous result stays visible until RUN starts shifting.
            if (bus.start) begin
               sha_d   = bus.A;
               shb_d   = bus.B;
               bflag_d = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            diff_d  = {bit_diff, diff_q[N-1:1]};
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            bflag_d = bit_borrow;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               borrow_d = bit_borrow;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.Diff   = diff_q;
   assign bus.Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus a random
// sweep, each result compared with {Borrow,Diff} = {0,A} - {0,B}.
module tb_serial_subtractor;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   serial_subtractor_if #(.N(N)) bus8 ();
   serial_subtractor_if #(.N(2)) bus2 ();

   serial_subtractor #(.N(N)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   serial_subtractor #(.N(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: unsigned subtraction widened by one bit; the top bit is the borrow.
   function automatic logic [N:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b);
      return {1'b0, a} - {1'b0, b};
   endfunction

   // Issue one operation on the 8-bit DUT (must be idle) and wait for done.
   // lat = edges after the accepting edge until done is seen (-1 on timeout);
   // done_after = done one cycle after it was seen. Returns with the DUT idle.
   task automatic op8(input logic [N-1:0] a, input logic [N-1:0] b,
                      output int lat, output logic [N-1:0] d, output logic bo,
                      output logic done_after);
      bus8.A     = a;
      bus8.B     = b;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus8.done) begin
            lat = k;
            break;
         end
      end
      d  = bus8.Diff;
      bo = bus8.Borrow;
      tick();
      done_after = bus8.done;
      $display("op A=%h B=%h -> Diff=%h Borrow=%b lat=%0d", a, b, d, bo, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus8.start = 1'b1;  // reset must dominate start
      bus8.A = 8'hAA;
      bus8.B = 8'h55;
      bus2.start = 1'b0;
      bus2.A = '0;
      bus2.B = '0;
      tick();
      tick();
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus8.busy); end
      checks++;
      if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus8.done); end
      checks++;
      if (bus8.Diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h expected 00", bus8.Diff); end
      checks++;
      if (bus8.Borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", bus8.Borrow); end
      bus8.start = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      logic [N-1:0] d;
      logic bo, da;
      op8(8'h5A, 8'h23, lat, d, bo, da);
      // start high in cycle t -> done in cycle t+N+1, i.e. N edges after acceptance
      checks++;
      if (lat != N) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, N); end
      checks++;
      if ({bo, d} !== {1'b0, 8'h37}) begin errors++; $display("FAIL basic_result: got %b/%h expected 0/37", bo, d); end
      checks++;
      if (da !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", da); end
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", bus8.busy); end
   endtask

   task automatic test_borrow();
      int lat;
      logic [N-1:0] d;
      logic bo, da;
      op8(8'h10, 8'h20, lat, d, bo, da);
      checks++;
      if ({bo, d} !== {1'b1, 8'hF0}) begin errors++; $display("FAIL borrow_result: got %b/%h expected 1/f0", bo, d); end
      op8(8'hFF, 8'hFF, lat, d, bo, da);
      checks++;
      if ({bo, d} !== {1'b0, 8'h00}) begin errors++; $display("FAIL equal_result: got %b/%h expected 0/00", bo, d); end
   endtask

   task automatic test_hold();
      int lat;
      logic [N-1:0] d;
      logic bo, da;
      op8(8'h00, 8'h01, lat, d, bo, da);
      checks++;
      if ({bo, d} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL underflow_result: got %b/%h expected 1/ff", bo, d); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({bus8.Borrow, bus8.Diff} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL hold_cycle%0d: got %b/%h expected 1/ff", k, bus8.Borrow, bus8.Diff);
         end
      end
   endtask

   task automatic test_ignore_busy();
      logic [N-1:0] a1, b1;
      logic [N:0] exp9;
      logic [N:0] got9;
      int ndone = 0;
      int lat = -1;
      a1 = N'($urandom);
      b1 = N'($urandom);
      exp9 = ref_sub(a1, b1);
      got9 = '0;
      bus8.A = a1;
      bus8.B = b1;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 2) begin
            bus8.start = 1'b1;
            bus8.A = ~a1;
            bus8.B = b1 + 8'h17;
         end
         if (k == 3) bus8.start = 1'b0;
         tick();
         if (bus8.done) begin
            ndone++;
            if (ndone == 1) begin
               lat = k;
               got9 = {bus8.Borrow, bus8.Diff};
            end
         end
      end
      $display("op A=%h B=%h (restart attempted) -> Borrow/Diff=%h dones=%0d", a1, b1, got9, ndone);
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
      checks++;
      if (got9 !== exp9) begin errors++; $display("FAIL ignore_result: got %h expected %h", got9, exp9); end
      checks++;
      if (lat != N) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, N); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int ndone = 0;
      logic [N-1:0] d;
      logic bo, da;
      bus8.A = 8'hC4;
      bus8.B = 8'h3B;
      bus8.start = 1'b1;
      tick();           // now in RUN cycle 1
      bus8.start = 1'b0;
      tick();
      tick();
      tick();           // now in RUN cycle 4
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus8.busy, bus8.done, bus8.Borrow, bus8.Diff} !== 11'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got busy=%b done=%b borrow=%b diff=%h expected all 0",
                  bus8.busy, bus8.done, bus8.Borrow, bus8.Diff);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus8.done) ndone++;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
      op8(8'h03, 8'h01, lat, d, bo, da);
      checks++;
      if ({bo, d} !== {1'b0, 8'h02}) begin errors++; $display("FAIL midrst_next_op: got %b/%h expected 0/02", bo, d); end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a, b;
      logic [N:0] exp9;
      int last_done = -1;
      int nops = 0;
      a = N'($urandom);
      b = N'($urandom);
      exp9 = ref_sub(a, b);
      bus8.A = a;
      bus8.B = b;
      bus8.start = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 80 && nops < 4; cyc++) begin
         tick();
         if (bus8.done) begin
            nops++;
            $display("op A=%h B=%h (start held) -> Diff=%h Borrow=%b at cycle %0d",
                     a, b, bus8.Diff, bus8.Borrow, cyc);
            checks++;
            if ({bus8.Borrow, bus8.Diff} !== exp9) begin
               errors++;
               $display("FAIL b2b_result%0d: got %h expected %h", nops, {bus8.Borrow, bus8.Diff}, exp9);
            end
            if (last_done >= 0) begin
               checks++;
               if (cyc - last_done != N + 2) begin
                  errors++;
                  $display("FAIL b2b_interval%0d: got %0d expected %0d", nops, cyc - last_done, N + 2);
               end
            end
            last_done = cyc;
            // New operands are captured two edges later, on re-acceptance.
            a = N'($urandom);
            b = N'($urandom);
            exp9 = ref_sub(a, b);
            bus8.A = a;
            bus8.B = b;
            if (nops == 4) bus8.start = 1'b0;
         end
      end
      bus8.start = 1'b0;
      checks++;
      if (nops != 4) begin errors++; $display("FAIL b2b_op_count: got %0d expected 4", nops); end
      tick();
      tick();
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b expected 0", bus8.busy); end
   endtask

   task automatic test_narrow();
      int lat = -1;
      logic [2:0] got;
      bus2.A = 2'b01;
      bus2.B = 2'b10;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus2.done) begin
            lat = k;
            break;
         end
      end
      got = {bus2.Borrow, bus2.Diff};
      $display("op N=2 A=01 B=10 -> Borrow/Diff=%b lat=%0d", got, lat);
      checks++;
      if (got !== 3'b111) begin errors++; $display("FAIL narrow_result: got %b expected 111", got); end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL narrow_latency: got %0d expected 2", lat); end
      tick();
   endtask

   task automatic test_random();
      int lat;
      logic [N-1:0] a, b, d;
      logic bo, da;
      logic [N:0] exp9;
      for (int i = 0; i < 1000; i++) begin
         a = N'($urandom);
         b = N'($urandom);
         if (i % 16 == 0) b = a;   // sprinkle in equal operands
         exp9 = ref_sub(a, b);
         op8(a, b, lat, d, bo, da);
         checks++;
         if ({bo, d} !== exp9) begin
            errors++;
            $display("FAIL rand_result%0d: A=%h B=%h got %h expected %h", i, a, b, {bo, d}, exp9);
         end
         checks++;
         if (lat != N || da !== 1'b0) begin
            errors++;
            $display("FAIL rand_timing%0d: got lat=%0d done_after=%b expected lat=%0d done_after=0",
                     i, lat, da, N);
         end
      end
   endtask

   initial begin
      bus8.start = 1'b0;
      bus8.A = '0;
      bus8.B = '0;
      test_reset();
      test_basic();
      test_borrow();
      test_hold();
      test_ignore_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_narrow();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
